// File: rtl/riscv_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package riscv_fetch_pkg;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular queue holding {instruction, address} pairs for decode.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full queue is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
            count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues PC reads, queues returns, redirects on JAL.
// Optional perf counters are built only when FETCH_PERF_EN is defined.
module fetch_stage
    import riscv_fetch_pkg::*;
#(
    parameter int ADDR_W  = riscv_fetch_pkg::ADDR_W,
    parameter int INSTR_W = riscv_fetch_pkg::INSTR_W,
    parameter int DEPTH   = riscv_fetch_pkg::DEPTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_hold,
    output logic [ADDR_W-1:0]  jump_out,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        flush_cnt
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_e       state_q;
    logic               boot_q;
    logic               inflight_q;
    logic [ADDR_W-1:0]  tag_q;
    logic [INSTR_W-1:0] last_instr_q;
    logic [ADDR_W-1:0]  last_pc_q;

    logic [ENTRY_W-1:0] head;
    logic [INSTR_W-1:0] head_instr;
    logic [ADDR_W-1:0]  head_pc;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occupancy;
    logic               pop, push, jal_pop;

    assign head_instr = head[ENTRY_W-1:ADDR_W];
    assign head_pc    = head[ADDR_W-1:0];

    assign pop     = ~fifo_empty & instr_ready;
    assign jal_pop = pop & (head_instr[6:0] == OPC_JAL);

    // Entries already held plus the read still in flight, less what leaves now.
    assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign pc_hold   = boot_q | (state_q == FLUSH) | (occupancy >= (CNT_W+1)'(DEPTH));

    // No issue on a JAL pop: that read would be wrong-path and land during FLUSH.
    assign imem_en   = (state_q == RUN) & ~pc_hold & ~jal_pop;
    assign imem_addr = imem_en ? pc_addr : '0;

    assign push     = inflight_q & ~jal_pop & (~fifo_full | pop);
    assign jump_out = jal_pop ? head_instr[27:22] : '0;

    assign instr_valid = ~fifo_empty;
    assign instr       = fifo_empty ? last_instr_q : head_instr;
    assign instr_pc    = fifo_empty ? last_pc_q : head_pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (jal_pop),
        .wdata_i ({imem_rdata, tag_q}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            boot_q       <= 1'b1;
            inflight_q   <= 1'b0;
            last_instr_q <= '0;
            last_pc_q    <= '0;
        end else begin
            boot_q     <= 1'b0;
            inflight_q <= imem_en;
            case (state_q)
                RUN:     if (jal_pop) state_q <= FLUSH;
                FLUSH:   state_q <= RUN;
                default: state_q <= RUN;
            endcase
            if (pop) begin
                last_instr_q <= head_instr;
                last_pc_q    <= head_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_en) begin
            tag_q <= pc_addr;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_hold && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
            if (jal_pop && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: program-order model over a random instruction memory.
module tb_fetch_stage;
    import riscv_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  pc_addr;
    logic        pc_hold;
    logic [5:0]  jump_out;
    logic        imem_en;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  instr_pc;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .pc_addr     (pc_addr),
        .pc_hold     (pc_hold),
        .jump_out    (jump_out),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    logic [31:0] mem [64];

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model: next address expected at decode in program order.
    logic [5:0]  exp_pc;
    int          hold_acc, jal_acc, pops;
    bit          prev_stall, first_issue_seen, last_hold;
    logic [5:0]  prev_pc;
    logic [31:0] prev_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc           = '0;
        hold_acc         = 0;
        jal_acc          = 0;
        prev_stall       = 1'b0;
        first_issue_seen = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, instr_valid, 0);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_ipc"}, instr_pc, 0);
        chk({tag, "_en"}, imem_en, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_jump"}, jump_out, 0);
        chk({tag, "_hold"}, pc_hold, 1);
        chk({tag, "_stall"}, stall_cnt, 0);
        chk({tag, "_flush"}, flush_cnt, 0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit rdy);
        logic [31:0] w;
        logic [5:0]  pc_nxt;
        bit          jal;
        jal         = 1'b0;
        instr_ready = rdy;
        #1;
        if (prev_stall) begin
            chk("stable_valid", instr_valid, 1);
            chk("stable_pc", instr_pc, prev_pc);
            chk("stable_instr", instr, prev_instr);
        end
`ifdef FETCH_PERF_EN
        chk("stall_cnt", stall_cnt, 32'(hold_acc));
        chk("flush_cnt", flush_cnt, 32'(jal_acc));
`else
        chk("stall_cnt_off", stall_cnt, 0);
        chk("flush_cnt_off", flush_cnt, 0);
`endif
        if (instr_valid && instr_ready) begin
            w = mem[exp_pc];
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr", instr, w);
            if (w[6:0] == OPC_JAL) begin
                chk("jump_jal", jump_out, w[27:22]);
                jal    = 1'b1;
                exp_pc = exp_pc + w[27:22];
                jal_acc++;
            end else begin
                chk("jump_seq", jump_out, 0);
                exp_pc = exp_pc + 6'd1;
            end
            pops++;
        end else begin
            chk("jump_idle", jump_out, 0);
        end
        if (imem_en) begin
            chk("imem_addr", imem_addr, pc_addr);
            if (!first_issue_seen) begin
                chk("first_addr", imem_addr, 0);
                first_issue_seen = 1'b1;
            end
        end
        // Surrounding PC: JAL target is the JAL's own address plus offset.
        if (jal)          pc_nxt = exp_pc;
        else if (!pc_hold) pc_nxt = pc_addr + 6'd1;
        else              pc_nxt = pc_addr;
        if (pc_hold) hold_acc++;
        last_hold  = pc_hold;
        prev_stall = instr_valid & ~instr_ready;
        prev_pc    = instr_pc;
        prev_instr = instr;
        @(posedge clk);
        #1;
        pc_addr = pc_nxt;
        @(negedge clk);
    endtask

    initial begin
        int p0;
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (w[6:0] == OPC_JAL) w[0] = 1'b0;
            mem[i] = w;
        end
        w = $urandom; mem[3]  = {w[31:28], 6'd4,  w[21:7], OPC_JAL};
        w = $urandom; mem[9]  = {w[31:28], 6'd30, w[21:7], OPC_JAL};
        w = $urandom; mem[50] = {w[31:28], 6'd20, w[21:7], OPC_JAL};

        pops        = 0;
        instr_ready = 1'b0;
        pc_addr     = '0;
        reset       = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Streaming with decode always ready, through the JAL at address 3.
        step(1'b1);
        chk("boot_hold", last_hold, 1);
        step(1'b1);
        chk("run_hold", last_hold, 0);
        p0 = pops;
        repeat (30) step(1'b1);
        chk("progress_stream", pops > p0 + 10, 1);

        // Decode stalls: queue fills and the PC must be held.
        repeat (5) step(1'b0);
        chk("full_hold", last_hold, 1);
        chk("full_valid", instr_valid, 1);
        p0 = pops;
        repeat (10) step(1'b1);
        chk("progress_release", pops > p0, 1);

        // Random decode back-pressure.
        repeat (300) step(($urandom_range(0, 3) != 0));

        // Asynchronous reset with data queued and a read outstanding.
        repeat (4) step(1'b1);
        step(1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        pc_addr     = '0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b1);
        chk("reboot_hold", last_hold, 1);
        p0 = pops;
        repeat (300) step(($urandom_range(0, 4) != 0));
        chk("progress_final", pops > p0 + 50, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
